// File: rtl/parking_pkg.sv
// Shared definitions for the exit-side parking slot release logic.
// Contents: slot count, default fee width, FSM state encodings, and a
// highest-set-bit helper used to pick the departing car's slot.
package parking_pkg;

  localparam int unsigned SLOT_COUNT    = 8;
  localparam int unsigned DEFAULT_FEE_W = 8;
  localparam int unsigned STATE_W       = 3;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_RELEASE = 3'd2;
  localparam logic [2:0] ST_GATE    = 3'd3;
  localparam logic [2:0] ST_ERR     = 3'd4;

  // Index of the highest set bit; 0 when the vector is empty.
  function automatic logic [2:0] hsb_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/release_parking_slot_if.sv
// Exit-lane / occupancy-register bus of release_parking_slot.
// master: exit-lane request logic and occupancy register side.
// slave : release_parking_slot itself.
// Optional macro GATE_SENSOR_EN adds the car_passed sensor input.
interface release_parking_slot_if #(
  parameter int unsigned FEE_W = 8
);
  logic             exit_valid;
  logic             exit_ready;
  logic [7:0]       leave_location;
  logic [7:0]       parking_capacity;
  logic [7:0]       new_capacity;
  logic             capacity_we;
  logic [FEE_W-1:0] fee;
  logic             fee_valid;
  logic             gate_open;
  logic             exit_err;
`ifdef GATE_SENSOR_EN
  logic             car_passed;

  modport master (
    output exit_valid, leave_location, parking_capacity, car_passed,
    input  exit_ready, new_capacity, capacity_we, fee, fee_valid, gate_open, exit_err
  );

  modport slave (
    input  exit_valid, leave_location, parking_capacity, car_passed,
    output exit_ready, new_capacity, capacity_we, fee, fee_valid, gate_open, exit_err
  );
`else
  modport master (
    output exit_valid, leave_location, parking_capacity,
    input  exit_ready, new_capacity, capacity_we, fee, fee_valid, gate_open, exit_err
  );

  modport slave (
    input  exit_valid, leave_location, parking_capacity,
    output exit_ready, new_capacity, capacity_we, fee, fee_valid, gate_open, exit_err
  );
`endif
endinterface

// File: rtl/slot_timer.sv
// Per-slot occupancy timer: cleared while the slot is empty, otherwise
// counts fee units on each tick and saturates at all-ones.
// Ports: clk, reset (async, active-high), occupied, tick -> count.
module slot_timer #(
  parameter int unsigned FEE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             occupied,
  input  logic             tick,
  output logic [FEE_W-1:0] count
);

  localparam logic [FEE_W-1:0] COUNT_MAX = '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!occupied) begin
      count <= '0;
    end else if (tick && (count != COUNT_MAX)) begin
      count <= count + FEE_W'(1);
    end
  end

endmodule

// File: rtl/release_parking_slot.sv
// Frees a departing car's slot in the 8-bit occupancy map, reports its
// parking fee (elapsed fee units, saturating) and pulses the exit gate.
// Ports: clk, reset (async, active-high), bus (release_parking_slot_if.slave):
//   exit_valid/exit_ready request handshake, leave_location (highest set bit
//   selects the slot), parking_capacity in, new_capacity/capacity_we
//   write-back, fee/fee_valid, gate_open, exit_err.
// Optional macro GATE_SENSOR_EN: gate closes on car_passed or after a
// 4*GATE_CYCLES timeout instead of after GATE_CYCLES fixed cycles.
module release_parking_slot
  import parking_pkg::*;
#(
  parameter int unsigned TICKS_PER_UNIT = 16,
  parameter int unsigned GATE_CYCLES    = 4,
  parameter int unsigned FEE_W          = DEFAULT_FEE_W
) (
  input logic                   clk,
  input logic                   reset,
  release_parking_slot_if.slave bus
);

`ifdef GATE_SENSOR_EN
  localparam int unsigned GATE_LIMIT = 4 * GATE_CYCLES;
`else
  localparam int unsigned GATE_LIMIT = GATE_CYCLES;
`endif
  localparam int unsigned PRESC_W = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int unsigned GCNT_W  = (GATE_LIMIT > 1) ? $clog2(GATE_LIMIT) : 1;

  // Fee-unit prescaler; the wrap cycle is the unit tick.
  logic [PRESC_W-1:0] presc;
  logic               tick;

  assign tick = (presc == PRESC_W'(TICKS_PER_UNIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

  // One occupancy timer per slot.
  logic [FEE_W-1:0] timer [SLOT_COUNT];

  for (genvar g = 0; g < SLOT_COUNT; g++) begin : g_slot
    slot_timer #(
      .FEE_W(FEE_W)
    ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .occupied (bus.parking_capacity[g]),
      .tick     (tick),
      .count    (timer[g])
    );
  end

  // FSM and registered outputs.
  logic [STATE_W-1:0] state, state_next;
  logic [2:0]         slot_q, slot_d;
  logic               no_slot_q, no_slot_d;
  logic [GCNT_W-1:0]  gate_cnt, gate_cnt_d;
  logic               gate_done;
  logic [7:0]         sel_mask;

  logic               ready_q, ready_d;
  logic               we_q, we_d;
  logic               fee_valid_q, fee_valid_d;
  logic               gate_q, gate_d;
  logic               err_q, err_d;
  logic [7:0]         new_cap_q, new_cap_d;
  logic [FEE_W-1:0]   fee_q, fee_d;

  assign sel_mask = 8'(1) << slot_q;

`ifdef GATE_SENSOR_EN
  assign gate_done = bus.car_passed || (gate_cnt == GCNT_W'(GATE_LIMIT - 1));
`else
  assign gate_done = (gate_cnt == GCNT_W'(GATE_LIMIT - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      slot_q      <= '0;
      no_slot_q   <= 1'b0;
      gate_cnt    <= '0;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      fee_valid_q <= 1'b0;
      gate_q      <= 1'b0;
      err_q       <= 1'b0;
      new_cap_q   <= '0;
      fee_q       <= '0;
    end else begin
      state       <= state_next;
      slot_q      <= slot_d;
      no_slot_q   <= no_slot_d;
      gate_cnt    <= gate_cnt_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      fee_valid_q <= fee_valid_d;
      gate_q      <= gate_d;
      err_q       <= err_d;
      new_cap_q   <= new_cap_d;
      fee_q       <= fee_d;
    end
  end

  // Outputs are derived from the next state so they line up with it.
  always_comb begin
    state_next = state;
    slot_d      = slot_q;
    no_slot_d   = no_slot_q;
    gate_cnt_d  = gate_cnt;
    new_cap_d   = new_cap_q;
    fee_d       = fee_q;

    case (state)
      ST_IDLE: begin
        if (bus.exit_valid && ready_q) begin
          slot_d     = hsb_index(bus.leave_location);
          no_slot_d  = (bus.leave_location == 8'h00);
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // Occupancy seen here decides the outcome; the timer value taken
        // is the one before any coincident tick lands.
        if (no_slot_q || !bus.parking_capacity[slot_q]) begin
          state_next = ST_ERR;
        end else begin
          state_next = ST_RELEASE;
          new_cap_d  = bus.parking_capacity & ~sel_mask;
          fee_d      = timer[slot_q];
        end
      end
      ST_RELEASE: begin
        state_next = ST_GATE;
        gate_cnt_d = '0;
      end
      ST_GATE: begin
        if (gate_done) begin
          state_next = ST_IDLE;
        end else begin
          gate_cnt_d = gate_cnt + GCNT_W'(1);
        end
      end
      ST_ERR: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    ready_d     = (state_next == ST_IDLE);
    we_d        = (state_next == ST_RELEASE);
    fee_valid_d = (state_next == ST_RELEASE);
    gate_d      = (state_next == ST_GATE);
    err_d       = (state_next == ST_ERR);
  end

  assign bus.exit_ready   = ready_q;
  assign bus.capacity_we  = we_q;
  assign bus.fee_valid    = fee_valid_q;
  assign bus.gate_open    = gate_q;
  assign bus.exit_err     = err_q;
  assign bus.new_capacity = new_cap_q;
  assign bus.fee          = fee_q;

endmodule

// File: tb/tb_release_parking_slot.sv
// Self-checking bench for release_parking_slot: a transaction-level model
// predicts every output each cycle; directed scenarios pin literal values.
module tb_release_parking_slot;

  localparam int unsigned TPU         = 16;
  localparam int unsigned GATE_CYCLES = 4;
`ifdef GATE_SENSOR_EN
  localparam int GL = 4 * GATE_CYCLES;
`else
  localparam int GL = GATE_CYCLES;
`endif

  logic clk;
  logic reset;

  release_parking_slot_if #(.FEE_W(8)) bus ();

  release_parking_slot #(
    .TICKS_PER_UNIT (TPU),
    .GATE_CYCLES    (GATE_CYCLES),
    .FEE_W          (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: position within a transaction since acceptance,
  // plus per-slot unit counts derived from edges since reset.
  int         m_k;
  bit         m_ok;
  int         m_slot;
  bit         m_nos;
  int         m_edges;
  int         m_timer [8];
  int         e_fee;
  logic [7:0] e_newcap;

  always @(posedge clk or posedge reset) begin : model
    int  k;
    bit  ok;
    int  slot;
    bit  tick;
    if (reset) begin
      m_k      <= 0;
      m_ok     <= 1'b0;
      m_slot   <= 0;
      m_nos    <= 1'b0;
      m_edges  <= 0;
      e_fee    <= 0;
      e_newcap <= 8'h00;
      for (int i = 0; i < 8; i++) m_timer[i] <= 0;
    end else begin
      k  = m_k;
      ok = m_ok;
      if (k == 0) begin
        if (bus.exit_valid) begin
          slot = 0;
          for (int i = 0; i < 8; i++) if (bus.leave_location[i]) slot = i;
          m_slot <= slot;
          m_nos  <= (bus.leave_location == 8'h00);
          k = 1;
        end
      end else begin
        if (k == 1) begin
          ok = !m_nos && bus.parking_capacity[m_slot];
          if (ok) begin
            e_fee    <= m_timer[m_slot];
            e_newcap <= bus.parking_capacity & ~(8'(1) << m_slot);
          end
        end
        k++;
        if (k == (ok ? 3 + GL : 3)) k = 0;
      end
      m_k  <= k;
      m_ok <= ok;
      tick = ((m_edges % TPU) == TPU - 1);
      m_edges <= m_edges + 1;
      for (int i = 0; i < 8; i++) begin
        if (!bus.parking_capacity[i]) m_timer[i] <= 0;
        else if (tick && m_timer[i] < 255) m_timer[i] <= m_timer[i] + 1;
      end
    end
  end

  logic e_ready, e_we, e_err, e_gate;
  assign e_ready = (m_k == 0);
  assign e_we    = m_ok && (m_k == 2);
  assign e_err   = !m_ok && (m_k == 2);
  assign e_gate  = m_ok && (m_k >= 3);

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("exit_ready",   int'(bus.exit_ready),   int'(e_ready));
      chk("capacity_we",  int'(bus.capacity_we),  int'(e_we));
      chk("fee_valid",    int'(bus.fee_valid),    int'(e_we));
      chk("exit_err",     int'(bus.exit_err),     int'(e_err));
      chk("gate_open",    int'(bus.gate_open),    int'(e_gate));
      chk("new_capacity", int'(bus.new_capacity), int'(e_newcap));
      chk("fee",          int'(bus.fee),          e_fee);
    end
  end

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.exit_ready) seen = 1'b1;
    end
    chk("idle_timeout", int'(seen), 1);
  endtask

  // Presents one request and samples the strobes two cycles after acceptance.
  task automatic request(input logic [7:0] loc, output logic we, output logic err,
                         output logic [7:0] fee_s, output logic [7:0] cap_s);
    @(negedge clk);
    bus.exit_valid     = 1'b1;
    bus.leave_location = loc;
    @(negedge clk);
    bus.exit_valid     = 1'b0;
    @(negedge clk);
    we    = bus.capacity_we;
    err   = bus.exit_err;
    fee_s = bus.fee;
    cap_s = bus.new_capacity;
  endtask

  task automatic count_gate(output int n);
    n = 0;
    for (int i = 0; i < GL + 2; i++) begin
      @(negedge clk);
      if (bus.gate_open) n++;
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic       we, err;
    logic [7:0] fee_s, cap_s;
    int         ng, nr;

`ifdef GATE_SENSOR_EN
    bus.car_passed = 1'b0;
`endif
    reset                = 1'b0;
    bus.exit_valid       = 1'b0;
    bus.leave_location   = 8'h00;
    bus.parking_capacity = 8'b0010_0100;
    #1 reset = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_exit_ready", int'(bus.exit_ready), 1);
    chk("rst_new_cap",    int'(bus.new_capacity), 0);
    chk("rst_we",         int'(bus.capacity_we), 0);
    chk("rst_fee",        int'(bus.fee), 0);
    chk("rst_fee_valid",  int'(bus.fee_valid), 0);
    chk("rst_gate",       int'(bus.gate_open), 0);
    chk("rst_err",        int'(bus.exit_err), 0);
    reset = 1'b0;

    // Fee after 80 cycles of occupancy at 16 cycles per unit.
    repeat (80) @(negedge clk);
    request(8'b0000_0100, we, err, fee_s, cap_s);
    chk("fee5_we",     int'(we), 1);
    chk("fee5_fee",    int'(fee_s), 5);
    chk("fee5_newcap", int'(cap_s), 8'h20);
    count_gate(ng);
    chk("fee5_gate_len", ng, GL);
    bus.parking_capacity = cap_s;

    // Highest set bit wins.
    wait_idle();
    bus.parking_capacity = 8'b0100_0000;
    request(8'b0110_0000, we, err, fee_s, cap_s);
    chk("prio_we",     int'(we), 1);
    chk("prio_newcap", int'(cap_s), 8'h00);
    bus.parking_capacity = cap_s;

    // No slot selected.
    wait_idle();
    request(8'h00, we, err, fee_s, cap_s);
    chk("noslot_err", int'(err), 1);
    chk("noslot_we",  int'(we), 0);
    count_gate(ng);
    chk("noslot_gate", ng, 0);

    // Empty slot 3.
    wait_idle();
    bus.parking_capacity = 8'h00;
    request(8'b0000_1000, we, err, fee_s, cap_s);
    chk("empty_err", int'(err), 1);
    chk("empty_we",  int'(we), 0);
    count_gate(ng);
    chk("empty_gate", ng, 0);

    // Saturation over 300 units, then restart from zero.
    wait_idle();
    bus.parking_capacity = 8'h01;
    repeat (300 * TPU) @(negedge clk);
    request(8'h01, we, err, fee_s, cap_s);
    chk("sat_fee", int'(fee_s), 255);
    wait_idle();
    bus.parking_capacity = 8'h00;
    @(negedge clk);
    bus.parking_capacity = 8'h01;
    request(8'h01, we, err, fee_s, cap_s);
    chk("restart_fee_small", int'(fee_s <= 8'd1), 1);
    bus.parking_capacity = cap_s;

    // Back-to-back requests: one acceptance per 3+gate-length cycles.
    wait_idle();
    bus.parking_capacity = 8'hFF;
    bus.exit_valid       = 1'b1;
    bus.leave_location   = 8'h80;
    nr = 0;
    ng = 0;
    for (int i = 0; i < 10 * (3 + GL); i++) begin
      @(negedge clk);
      bus.leave_location = 8'($urandom_range(1, 255));
      if (bus.exit_ready) nr++;
      if (bus.gate_open) ng++;
    end
    bus.exit_valid = 1'b0;
    chk("bp_accepts",    nr, 10);
    chk("bp_gate_count", ng, 10 * GL);

    // Reset asserted while the gate is open.
    wait_idle();
    bus.parking_capacity = 8'h10;
    request(8'h10, we, err, fee_s, cap_s);
    @(negedge clk);
    chk("mid_gate_open", int'(bus.gate_open), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_gate",  int'(bus.gate_open), 0);
    chk("mid_rst_we",    int'(bus.capacity_we), 0);
    chk("mid_rst_ready", int'(bus.exit_ready), 1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Random traffic, with the occupancy register following write-backs.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (bus.capacity_we) bus.parking_capacity = bus.new_capacity;
      if ($urandom_range(0, 9) == 0)
        bus.parking_capacity = bus.parking_capacity | (8'(1) << $urandom_range(0, 7));
      if ($urandom_range(0, 39) == 0)
        bus.parking_capacity = bus.parking_capacity ^ (8'(1) << $urandom_range(0, 7));
      bus.exit_valid = 1'($urandom_range(0, 1));
      bus.leave_location = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
    end
    bus.exit_valid = 1'b0;
    repeat (2 * (3 + GL)) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
